mfrsd_spi_master: RTL and testbench

- SPI master for the MegaFlashROM SCC+ SD cartridge path.
- The slot subsystem issues byte requests and takes back received bytes over `d_to_sd`/`sd_tx`/`sd_rx`/`d_from_sd`. This block performs the serial transfer to the SD card.
- Mode 0, MSB first, full duplex.
- Each request moves one byte out and captures one byte in. A one-entry pending buffer lets the CPU issue back-to-back accesses without stalling the bus.

---
 rtl/mfrsd_spi_master.sv | 203 ++++++++++++++++++++
 tb/tb_mfrsd_spi_master.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfrsd_spi_master.sv
// SPI master (mode 0, MSB first, full duplex) for the MegaFlashROM SCC+ SD path.
// Each sd_tx / sd_rx pulse moves one byte out on spi_mosi and captures one byte
// from spi_miso. A one-entry pending buffer absorbs a request that arrives while
// a transfer is running, so back-to-back CPU accesses chain with no idle gap.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high
//   d_to_sd    byte to transmit, sampled with sd_tx
//   sd_tx      one-cycle pulse: transfer d_to_sd (wins over sd_rx)
//   sd_rx      one-cycle pulse: transfer IDLE_BYTE (read-ahead)
//   cs_sel     card select from mapper config register, 1 = selected
//   d_from_sd  last fully received byte
//   busy       transfer in progress or pending
//   spi_sclk   serial clock (idle low)
//   spi_mosi   serial data out (idle high)
//   spi_miso   serial data in, 2-flop synchronised internally
//   spi_cs_n   chip select, active low, registered copy of ~cs_sel
module mfrsd_spi_master #(
  parameter int unsigned CLK_DIV   = 2,
  parameter logic [7:0]  IDLE_BYTE = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] d_to_sd,
  input  logic       sd_tx,
  input  logic       sd_rx,
  input  logic       cs_sel,
  output logic [7:0] d_from_sd,
  output logic       busy,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_cs_n
);

  localparam int unsigned      DIV_W    = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  logic [6:0]       tx_sr;      // bits still to be sent after the one on spi_mosi
  logic [7:0]       rx_sr;
  logic [7:0]       pend_byte;
  logic             pend_valid;
  logic             miso_meta;
  logic             miso_sync;

  logic             req;
  logic [7:0]       req_byte;
  logic             div_zero;
  logic             last_bit;
  logic             start;
  logic             done;
  logic             store_req;
  logic [7:0]       start_byte;

  assign req        = sd_tx | sd_rx;
  assign req_byte   = sd_tx ? d_to_sd : IDLE_BYTE;
  assign div_zero   = (div_cnt == '0);
  assign last_bit   = (bit_cnt == 3'd7);
  // Any request seen outside IDLE (including the completion cycle) is parked.
  assign store_req  = req && (state != IDLE);
  // A fresh request in IDLE takes precedence over (and discards) a stale pending entry.
  assign start_byte = (state == IDLE && req) ? req_byte : pend_byte;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (req || pend_valid) begin
          start     = 1'b1;
          state_nxt = LOW;
        end
      end
      LOW: begin
        if (div_zero) begin
          state_nxt = HIGH;
        end
      end
      HIGH: begin
        if (div_zero) begin
          if (last_bit) begin
            done = 1'b1;
            if (pend_valid) begin
              start     = 1'b1;
              state_nxt = LOW;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            state_nxt = LOW;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state != IDLE) || pend_valid;
  end

  // Shift/count datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt    <= '0;
      bit_cnt    <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      pend_byte  <= '0;
      pend_valid <= 1'b0;
      spi_sclk   <= 1'b0;
      spi_mosi   <= 1'b1;
      d_from_sd  <= 8'hFF;
    end else begin
      if (store_req) begin
        pend_byte <= req_byte;
      end
      if (store_req) begin
        pend_valid <= 1'b1;
      end else if (start) begin
        pend_valid <= 1'b0;
      end

      case (state)
        LOW: begin
          if (div_zero) begin
            spi_sclk <= 1'b1;
            rx_sr    <= {rx_sr[6:0], miso_sync};
            div_cnt  <= DIV_LOAD;
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
        end
        HIGH: begin
          if (div_zero) begin
            spi_sclk <= 1'b0;
            if (last_bit) begin
              d_from_sd <= rx_sr;
              spi_mosi  <= 1'b1;
            end else begin
              bit_cnt  <= bit_cnt + 3'd1;
              tx_sr    <= {tx_sr[5:0], 1'b0};
              spi_mosi <= tx_sr[6];
              div_cnt  <= DIV_LOAD;
            end
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
        end
        default: begin
          spi_sclk <= 1'b0;
          spi_mosi <= 1'b1;
        end
      endcase

      // Loading a new byte overrides the idle/next-bit values above, which is
      // what lets a pending byte follow a completion with no idle cycle.
      if (start) begin
        tx_sr    <= start_byte[6:0];
        spi_mosi <= start_byte[7];
        bit_cnt  <= '0;
        div_cnt  <= DIV_LOAD;
      end
    end
  end

  // MISO synchroniser and chip select (independent of the transfer FSM)
  always_ff @(posedge clk) begin
    if (reset) begin
      miso_meta <= 1'b1;
      miso_sync <= 1'b1;
      spi_cs_n  <= 1'b1;
    end else begin
      miso_meta <= spi_miso;
      miso_sync <= miso_meta;
      spi_cs_n  <= ~cs_sel;
    end
  end

endmodule

// File: tb/tb_mfrsd_spi_master.sv
// Self-checking bench for mfrsd_spi_master: directed scenarios followed by a
// randomized request stream, checked against a transaction-level model (each
// transfer occupies 16*D cycles; one pending slot with overwrite) and an SPI
// slave model that presents bytes on spi_miso, shifting on falling SCLK.
module tb_mfrsd_spi_master;

  localparam int unsigned D = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] d_to_sd = 8'h00;
  logic       sd_tx = 1'b0;
  logic       sd_rx = 1'b0;
  logic       cs_sel = 1'b0;
  logic [7:0] d_from_sd;
  logic       busy;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_cs_n;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // miso source: loopback from mosi, or the slave model
  logic       loop_mode = 1'b1;
  logic [7:0] slave_sr = 8'hFF;
  int         slave_falls = 0;
  logic [7:0] sq[$];     // bytes the slave should present next
  logic [7:0] erq[$];    // bytes the slave has committed to, in transfer order

  // transaction model
  logic       m_active = 1'b0;
  logic       m_pv = 1'b0;
  int         m_left = 0;
  int         m_start = 0;
  logic [7:0] m_cur = 8'h00;
  logic [7:0] m_pb = 8'h00;
  logic [7:0] m_last = 8'hFF;

  // line monitor
  logic       prev_sclk = 1'b0;
  logic [7:0] mon_sr = 8'h00;
  int         mon_n = 0;
  int         busy_run = 0;

  assign spi_miso = loop_mode ? spi_mosi : slave_sr[7];

  mfrsd_spi_master #(
    .CLK_DIV  (D),
    .IDLE_BYTE(8'hFF)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .d_to_sd  (d_to_sd),
    .sd_tx    (sd_tx),
    .sd_rx    (sd_rx),
    .cs_sel   (cs_sel),
    .d_from_sd(d_from_sd),
    .busy     (busy),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_cs_n (spi_cs_n)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic slave_load();
    if (sq.size() > 0) slave_sr = sq.pop_front();
    else slave_sr = 8'($urandom);
    erq.push_back(slave_sr);
  endtask

  task automatic slave_reset();
    erq.delete();
    slave_falls = 0;
    slave_load();
  endtask

  task automatic start_xfer(input logic [7:0] b);
    m_active = 1'b1;
    m_left   = 16 * D;
    m_cur    = b;
    m_start  = cyc;
  endtask

  // One clock: apply current inputs at the edge, advance the model, check.
  task automatic tick();
    logic       req, rst_e, cs_e, was_active, pend_before, done;
    logic [7:0] rb, done_byte, exp_rx;
    req   = sd_tx | sd_rx;
    rb    = sd_tx ? d_to_sd : 8'hFF;
    rst_e = reset;
    cs_e  = cs_sel;
    done  = 1'b0;
    done_byte = 8'h00;
    @(posedge clk);
    #1;
    cyc++;
    sd_tx = 1'b0;
    sd_rx = 1'b0;

    if (rst_e) begin
      m_active = 1'b0;
      m_pv     = 1'b0;
      mon_n    = 0;
      m_last   = 8'hFF;
    end else begin
      was_active  = m_active;
      pend_before = m_pv;
      if (m_active) begin
        m_left--;
        if (m_left == 0) begin
          m_active  = 1'b0;
          done      = 1'b1;
          done_byte = m_cur;
        end
      end
      if (done && pend_before) begin
        start_xfer(m_pb);
        m_pv = 1'b0;
      end
      if (req) begin
        if (was_active) begin
          m_pv = 1'b1;
          m_pb = rb;
        end else begin
          start_xfer(rb);
          m_pv = 1'b0;
        end
      end else if (!m_active && m_pv) begin
        start_xfer(m_pb);
        m_pv = 1'b0;
      end
    end

    if (done) begin
      if (loop_mode) exp_rx = done_byte;
      else if (erq.size() > 0) exp_rx = erq.pop_front();
      else exp_rx = 8'hxx;
      m_last = exp_rx;
      chk("tx_byte", {24'd0, mon_sr}, {24'd0, done_byte});
      chk("bit_count", mon_n, 8);
      mon_n = 0;
    end

    if (spi_sclk && !prev_sclk) begin
      chk("sclk_rise_time", cyc - m_start, (2 * mon_n + 1) * D);
      mon_sr = {mon_sr[6:0], spi_mosi};
      mon_n++;
    end
    if (!loop_mode && !rst_e && prev_sclk && !spi_sclk) begin
      slave_falls++;
      if (slave_falls == 8) begin
        slave_falls = 0;
        slave_load();
      end else begin
        slave_sr = {slave_sr[6:0], 1'b0};
      end
    end
    prev_sclk = spi_sclk;

    chk("busy", {31'd0, busy}, {31'd0, (m_active || m_pv)});
    chk("cs_n", {31'd0, spi_cs_n}, {31'd0, (rst_e ? 1'b1 : ~cs_e)});
    chk("d_from_sd", {24'd0, d_from_sd}, {24'd0, m_last});
    if (busy) busy_run++;
  endtask

  task automatic run_idle(input int maxc);
    int n;
    n = 0;
    while ((m_active || m_pv || busy) && n < maxc) begin
      tick();
      n++;
    end
    chk("idle_timeout", {31'd0, (n >= maxc)}, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sclk"}, {31'd0, spi_sclk}, 32'd0);
    chk({tag, "_mosi"}, {31'd0, spi_mosi}, 32'd1);
    chk({tag, "_d"}, {24'd0, d_from_sd}, 32'hFF);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    int r;

    // Reset for two cycles
    reset = 1'b1;
    tick();
    tick();
    chk_reset_outputs("rst");
    chk("rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
    reset = 1'b0;
    cs_sel = 1'b1;
    tick();
    chk("cs_sel_on", {31'd0, spi_cs_n}, 32'd0);

    // Loopback write of 8'hA5
    loop_mode = 1'b1;
    busy_run = 0;
    d_to_sd = 8'hA5;
    sd_tx = 1'b1;
    tick();
    run_idle(40 * D);
    chk("loop_busy_len", busy_run, 16 * D);
    chk("loop_rx", {24'd0, d_from_sd}, 32'hA5);

    // Read-ahead with miso held low
    loop_mode = 1'b0;
    sq.push_back(8'h00);
    slave_reset();
    sd_rx = 1'b1;
    tick();
    run_idle(40 * D);
    chk("readahead_rx", {24'd0, d_from_sd}, 32'h00);

    // Back-to-back: second request lands in the pending slot
    loop_mode = 1'b1;
    busy_run = 0;
    d_to_sd = 8'h12;
    sd_tx = 1'b1;
    tick();
    repeat (4) tick();
    d_to_sd = 8'h34;
    sd_tx = 1'b1;
    tick();
    run_idle(80 * D);
    chk("b2b_busy_len", busy_run, 32 * D);
    chk("b2b_rx", {24'd0, d_from_sd}, 32'h34);

    // Pending overwrite: 8'h11 is replaced by 8'h22
    d_to_sd = 8'h55;
    sd_tx = 1'b1;
    tick();
    repeat (5) tick();
    d_to_sd = 8'h11;
    sd_tx = 1'b1;
    tick();
    repeat (3) tick();
    d_to_sd = 8'h22;
    sd_tx = 1'b1;
    tick();
    run_idle(80 * D);
    chk("overwrite_rx", {24'd0, d_from_sd}, 32'h22);

    // sd_tx and sd_rx together: sd_tx byte is sent
    d_to_sd = 8'h3C;
    sd_tx = 1'b1;
    sd_rx = 1'b1;
    tick();
    run_idle(40 * D);
    chk("priority_rx", {24'd0, d_from_sd}, 32'h3C);

    // Request exactly on the completion cycle goes to pending
    d_to_sd = 8'h5A;
    sd_tx = 1'b1;
    tick();
    repeat (16 * D - 1) tick();
    d_to_sd = 8'hC6;
    sd_tx = 1'b1;
    tick();
    chk("collide_busy", {31'd0, busy}, 32'd1);
    run_idle(40 * D);
    chk("collide_rx", {24'd0, d_from_sd}, 32'hC6);

    // Reset after three SCLK pulses
    d_to_sd = 8'h96;
    sd_tx = 1'b1;
    tick();
    n = 0;
    while (!(mon_n == 3 && !spi_sclk) && n < 20 * D) begin
      tick();
      n++;
    end
    chk("midrst_wait_timeout", {31'd0, (n >= 20 * D)}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_outputs("midrst");
    repeat (10 * D) tick();
    chk("midrst_no_sclk", mon_n, 0);
    d_to_sd = 8'hC3;
    sd_tx = 1'b1;
    tick();
    run_idle(40 * D);
    chk("midrst_after_rx", {24'd0, d_from_sd}, 32'hC3);

    // Randomized requests against the slave model
    loop_mode = 1'b0;
    slave_reset();
    repeat (3000) begin
      cs_sel = 1'($urandom);
      r = int'($urandom_range(0, 24));
      d_to_sd = 8'($urandom);
      if (r == 0) sd_tx = 1'b1;
      else if (r == 1) sd_rx = 1'b1;
      else if (r == 2) begin
        sd_tx = 1'b1;
        sd_rx = 1'b1;
      end
      tick();
    end
    run_idle(100 * D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
